// File: rtl/chunk_adder.sv
// chunk_adder: multi-cycle adder that sums CHUNK bits per clock.
// Optional unsigned saturation; reports carry-out and signed overflow.
module chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [KW-1:0]    k_q;
    logic             carry_q;
    logic             sat_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [IW-1:0]    base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] sum_next;
    logic             ovf_next;
    logic             last_chunk;
    logic             accept;
    logic             retire;

    // Bit offset of the chunk being added this cycle.
    assign base = IW'(int'(k_q) * CHUNK);

    assign a_chunk = a_q[base +: CHUNK];
    assign b_chunk = b_q[base +: CHUNK];

    assign chunk_sum = {1'b0, a_chunk}
                     + {1'b0, b_chunk}
                     + {{CHUNK{1'b0}}, carry_q};

    assign last_chunk = (k_q == KW'(N - 1));

    assign accept = in_valid && in_ready;
    assign retire = out_valid && out_ready;

    // Partial result with the current chunk merged in.
    always_comb begin
        acc_next = acc_q;
        acc_next[base +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    // Final flags and (optionally saturated) sum from the last chunk.
    always_comb begin
        ovf_next = (a_q[WIDTH-1] == b_q[WIDTH-1])
                && (acc_next[WIDTH-1] != a_q[WIDTH-1]);
        sum_next = acc_next;
        if (sat_q && chunk_sum[CHUNK]) begin
            sum_next = '1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            (state_q == IDLE): begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            (state_q == RUN): begin
                if (last_chunk) begin
                    state_d = DONE;
                end
            end
            (state_q == DONE): begin
                if (retire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Operand capture and chunk-serial accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sat_q   <= 1'b0;
            carry_q <= 1'b0;
            k_q     <= '0;
            acc_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            sat_q   <= sat;
            carry_q <= cin;
            k_q     <= '0;
            acc_q   <= '0;
        end else if (state_q == RUN) begin
            acc_q   <= acc_next;
            carry_q <= chunk_sum[CHUNK];
            if (last_chunk) begin
                k_q <= '0;
            end else begin
                k_q <= k_q + 1'b1;
            end
        end
    end

    // Visible result, updated only when entering DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if ((state_q == RUN) && last_chunk) begin
            sum_q  <= sum_next;
            cout_q <= chunk_sum[CHUNK];
            ovf_q  <= ovf_next;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunk_adder.sv
// tb_chunk_adder: scoreboard bench for chunk_adder at three geometries.
// Reference results come from plain integer arithmetic.
module tb_chunk_adder;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic       v8, r8, c8, s8, ov8, or8, co8, of8;
    logic [7:0] a8, b8, sum8;

    logic v1, r1, c1, s1, ov1, or1, co1, of1;
    logic a1, b1, sum1;

    logic        v32, r32, c32, s32, ov32, or32, co32, of32;
    logic [31:0] a32, b32, sum32;

    exp_t q8[$];
    exp_t q1[$];
    exp_t q32[$];
    exp_t e8, e1, e32, bp;

    int   vecs = 0;
    int   miscompares = 0;
    logic done32 = 1'b0;

    chunk_adder #(.WIDTH(8), .CHUNK(4)) u8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8), .in_ready(r8),
        .a(a8), .b(b8), .cin(c8), .sat(s8),
        .out_valid(ov8), .out_ready(or8),
        .sum(sum8), .cout(co8), .ovf(of8)
    );

    chunk_adder #(.WIDTH(1), .CHUNK(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v1), .in_ready(r1),
        .a(a1), .b(b1), .cin(c1), .sat(s1),
        .out_valid(ov1), .out_ready(or1),
        .sum(sum1), .cout(co1), .ovf(of1)
    );

    chunk_adder #(.WIDTH(32), .CHUNK(8)) u32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v32), .in_ready(r32),
        .a(a32), .b(b32), .cin(c32), .sat(s32),
        .out_valid(ov32), .out_ready(or32),
        .sum(sum32), .cout(co32), .ovf(of32)
    );

    function automatic exp_t model(input int w,
                                   input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic ci,
                                   input logic sa);
        logic [63:0] m;
        logic [63:0] full;
        exp_t e;
        m    = (64'd1 << w) - 64'd1;
        full = ({32'd0, a} & m) + ({32'd0, b} & m) + {63'd0, ci};
        e.c  = full[w];
        e.s  = full[31:0] & m[31:0];
        e.o  = (a[w-1] == b[w-1]) && (e.s[w-1] != a[w-1]);
        if (sa && e.c) e.s = m[31:0];
        return e;
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] want);
        vecs++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h",
                     nm, act, want);
        end
    endtask

    task automatic bad(input string nm, input string got,
                       input string want);
        vecs++;
        miscompares++;
        $display("FAIL %s: got %s, expected %s", nm, got, want);
    endtask

    function automatic logic rdy(input int id);
        case (id)
            0:       return r8;
            1:       return r1;
            default: return r32;
        endcase
    endfunction

    function automatic int qsize(input int id);
        case (id)
            0:       return q8.size();
            1:       return q1.size();
            default: return q32.size();
        endcase
    endfunction

    task automatic issue(input int id,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic ci,
                         input logic sa);
        int n;
        @(posedge clk);
        #1;
        case (id)
            0: begin
                v8 = 1'b1; a8 = a[7:0]; b8 = b[7:0];
                c8 = ci; s8 = sa;
            end
            1: begin
                v1 = 1'b1; a1 = a[0]; b1 = b[0];
                c1 = ci; s1 = sa;
            end
            default: begin
                v32 = 1'b1; a32 = a; b32 = b;
                c32 = ci; s32 = sa;
            end
        endcase
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy(id) && n < 200);
        if (!rdy(id)) begin
            bad("accept_timeout", "in_ready low", "in_ready high");
        end else begin
            case (id)
                0:       q8.push_back(model(8, a, b, ci, sa));
                1:       q1.push_back(model(1, a, b, ci, sa));
                default: q32.push_back(model(32, a, b, ci, sa));
            endcase
        end
        @(posedge clk);
        #1;
        case (id)
            0: begin
                v8 = 1'b0; a8 = ~a8; b8 = ~b8;
                c8 = ~c8; s8 = ~s8;
            end
            1: begin
                v1 = 1'b0; a1 = ~a1; b1 = ~b1;
                c1 = ~c1; s1 = ~s1;
            end
            default: begin
                v32 = 1'b0; a32 = ~a32; b32 = ~b32;
                c32 = ~c32; s32 = ~s32;
            end
        endcase
    endtask

    task automatic drain(input int id);
        int n;
        n = 0;
        while (qsize(id) != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (qsize(id) != 0) begin
            bad("drain_timeout", "results pending", "queue empty");
        end
    endtask

    task automatic wait_valid8();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ov8 && n < 20);
        if (!ov8) begin
            bad("valid_timeout", "out_valid low", "out_valid high");
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && ov8 && or8) begin
            if (q8.size() == 0) begin
                bad("w8_unexpected", "result", "no result");
            end else begin
                e8 = q8.pop_front();
                chk("w8_sum", {24'd0, sum8}, e8.s);
                chk("w8_cout", {31'd0, co8}, {31'd0, e8.c});
                chk("w8_ovf", {31'd0, of8}, {31'd0, e8.o});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov1 && or1) begin
            if (q1.size() == 0) begin
                bad("w1_unexpected", "result", "no result");
            end else begin
                e1 = q1.pop_front();
                chk("w1_sum", {31'd0, sum1}, e1.s);
                chk("w1_cout", {31'd0, co1}, {31'd0, e1.c});
                chk("w1_ovf", {31'd0, of1}, {31'd0, e1.o});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov32 && or32) begin
            if (q32.size() == 0) begin
                bad("w32_unexpected", "result", "no result");
            end else begin
                e32 = q32.pop_front();
                chk("w32_sum", sum32, e32.s);
                chk("w32_cout", {31'd0, co32}, {31'd0, e32.c});
                chk("w32_ovf", {31'd0, of32}, {31'd0, e32.o});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        v8 = 0; a8 = 0; b8 = 0; c8 = 0; s8 = 0; or8 = 1;
        v1 = 0; a1 = 0; b1 = 0; c1 = 0; s1 = 0; or1 = 1;
        v32 = 0; a32 = 0; b32 = 0; c32 = 0; s32 = 0; or32 = 1;

        #2;
        chk("rst0_out_valid", {31'd0, ov8}, 32'd0);
        chk("rst0_in_ready", {31'd0, r8}, 32'd1);
        chk("rst0_sum", {24'd0, sum8}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        issue(0, 32'h3C, 32'h0F, 1'b0, 1'b0);
        @(negedge clk);
        chk("lat1_out_valid", {31'd0, ov8}, 32'd0);
        chk("lat1_in_ready", {31'd0, r8}, 32'd0);
        @(negedge clk);
        chk("lat2_out_valid", {31'd0, ov8}, 32'd0);
        chk("lat2_in_ready", {31'd0, r8}, 32'd0);
        @(negedge clk);
        chk("lat3_out_valid", {31'd0, ov8}, 32'd1);
        chk("lat3_in_ready", {31'd0, r8}, 32'd0);
        @(negedge clk);
        chk("lat4_out_valid", {31'd0, ov8}, 32'd0);
        chk("lat4_in_ready", {31'd0, r8}, 32'd1);

        issue(0, 32'hFF, 32'h01, 1'b0, 1'b0);
        issue(0, 32'hFF, 32'h01, 1'b0, 1'b1);
        issue(0, 32'h7F, 32'h00, 1'b1, 1'b0);
        drain(0);

        @(posedge clk);
        #1 or8 = 1'b0;
        issue(0, 32'h90, 32'h90, 1'b0, 1'b0);
        bp = model(8, 32'h90, 32'h90, 1'b0, 1'b0);
        wait_valid8();
        @(posedge clk);
        #1;
        v8 = 1'b1; a8 = 8'h11; b8 = 8'h22; c8 = 1'b0; s8 = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_sum", {24'd0, sum8}, bp.s);
            chk("bp_cout", {31'd0, co8}, {31'd0, bp.c});
            chk("bp_ovf", {31'd0, of8}, {31'd0, bp.o});
            chk("bp_in_ready", {31'd0, r8}, 32'd0);
            chk("bp_out_valid", {31'd0, ov8}, 32'd1);
        end
        @(posedge clk);
        #1 or8 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!r8 && n < 20);
        if (!r8) begin
            bad("bp_reaccept", "in_ready low", "in_ready high");
        end else begin
            q8.push_back(model(8, 32'h11, 32'h22, 1'b0, 1'b0));
        end
        @(posedge clk);
        #1 v8 = 1'b0;
        drain(0);

        @(posedge clk);
        #1 or8 = 1'b0;
        issue(0, 32'h90, 32'h90, 1'b0, 1'b0);
        wait_valid8();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", {31'd0, ov8}, 32'd0);
        chk("rst_mid_sum", {24'd0, sum8}, 32'd0);
        chk("rst_mid_cout", {31'd0, co8}, 32'd0);
        chk("rst_mid_ovf", {31'd0, of8}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, r8}, 32'd1);
        q8.delete();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 or8 = 1'b1;

        issue(0, 32'h55, 32'h22, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_run_in_ready", {31'd0, r8}, 32'd1);
        chk("rst_run_out_valid", {31'd0, ov8}, 32'd0);
        q8.delete();
        #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst_run_no_result", {31'd0, ov8}, 32'd0);
        end
        issue(0, 32'h01, 32'h01, 1'b0, 1'b0);
        drain(0);

        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                issue(1, 32'(i), 32'(j), 1'b0, 1'b0);
            end
        end
        drain(1);

        issue(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        issue(2, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
        issue(2, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        issue(2, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        drain(2);

        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    issue(2, $urandom, $urandom,
                          1'($urandom), 1'($urandom));
                    if ($urandom_range(0, 3) == 0) @(posedge clk);
                end
                done32 = 1'b1;
            end
            begin
                while (!done32) begin
                    @(posedge clk);
                    #1 or32 = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(posedge clk);
        #1 or32 = 1'b1;
        drain(2);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, miscompares);
        $finish;
    end

endmodule
